// File: rtl/axi4_sram_slave_if.sv
// AXI4 bus bundle between the CPU io_master and the SRAM responder.
// The slave modport is the memory side; the master modport is the initiator.
interface axi4_sram_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic              awready;
  logic              awvalid;
  logic [ADDR_W-1:0] awaddr;
  logic [ID_W-1:0]   awid;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;

  logic                wready;
  logic                wvalid;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;

  logic            bvalid;
  logic            bready;
  logic [1:0]      bresp;
  logic [ID_W-1:0] bid;

  logic              arready;
  logic              arvalid;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [ID_W-1:0]   rid;

  modport slave (
    output awready,
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output wready,
    input  wvalid, wdata, wstrb, wlast,
    output bvalid, bresp, bid,
    input  bready,
    output arready,
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output rvalid, rdata, rresp, rlast, rid,
    input  rready
  );

  modport master (
    input  awready,
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  wready,
    output wvalid, wdata, wstrb, wlast,
    input  bvalid, bresp, bid,
    output bready,
    input  arready,
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  rvalid, rdata, rresp, rlast, rid,
    output rready
  );
endinterface

// File: rtl/axi4_sram_slave.sv
// AXI4 responder backed by a word-addressed SRAM.
// One transaction at a time; round-robin between write and read.
module axi4_sram_slave #(
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 32,
  parameter int              ID_W      = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int              DEPTH     = 4096
) (
  input logic clock,
  input logic reset,
  axi4_sram_slave_if.slave bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(DEPTH * BYTES);

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

  state_t state, state_nx;

  logic              rr_rd;
  logic [ADDR_W-1:0] addr;
  logic [ID_W-1:0]   id;
  logic [7:0]        len;
  logic [2:0]        size;
  logic              fixed;
  logic              slv;
  logic              dec;
  logic [8:0]        cnt;

  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q, bresp_q;
  logic              rlast_q;
  logic [ID_W-1:0]   rid_q, bid_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              gnt_w, gnt_r;
  logic              aw_hs, ar_hs, w_hs, r_hs;
  logic              aw_slv, ar_slv, beat_slv;
  logic [ADDR_W-1:0] baddr, off, naddr;
  logic [2:0]        bsize;
  logic              bfixed, in_rng;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        beat_resp;

  assign gnt_w = bus.awvalid && (!bus.arvalid || !rr_rd);
  assign gnt_r = bus.arvalid && !gnt_w;
  assign aw_hs = (state == IDLE) && gnt_w;
  assign ar_hs = (state == IDLE) && gnt_r;
  assign w_hs  = (state == WDATA) && bus.wvalid;
  assign r_hs  = (state == RDATA) && bus.rready;

  assign aw_slv = (bus.awsize > 3'(LB)) || bus.awburst[1];
  assign ar_slv = (bus.arsize > 3'(LB)) || bus.arburst[1];

  // In IDLE the beat logic looks at AR so the first read word is fetched on the handshake
  assign baddr    = (state == IDLE) ? bus.araddr : addr;
  assign bsize    = (state == IDLE) ? bus.arsize : size;
  assign bfixed   = (state == IDLE) ? (bus.arburst == 2'b00) : fixed;
  assign beat_slv = (state == IDLE) ? ar_slv : slv;

  assign off    = baddr - BASE_ADDR;
  assign in_rng = off < SPAN;
  assign idx    = off[LB +: IDX_W];
  assign naddr  = bfixed ? baddr : baddr + (ADDR_W'(1) << bsize);

  assign beat_resp = !in_rng ? 2'b11 : (beat_slv ? 2'b10 : 2'b00);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    bus.awready = 1'b0;
    bus.arready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.rvalid  = 1'b0;
    unique case (state)
      IDLE: begin
        bus.awready = gnt_w;
        bus.arready = gnt_r;
        if (gnt_w)      state_nx = WDATA;
        else if (gnt_r) state_nx = RDATA;
      end
      WDATA: begin
        bus.wready = 1'b1;
        if (bus.wvalid && bus.wlast) state_nx = WRESP;
      end
      WRESP: begin
        bus.bvalid = 1'b1;
        if (bus.bready) state_nx = IDLE;
      end
      RDATA: begin
        bus.rvalid = 1'b1;
        if (bus.rready && rlast_q) state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_rd   <= 1'b0;
      addr    <= '0;
      id      <= '0;
      len     <= '0;
      size    <= '0;
      fixed   <= 1'b0;
      slv     <= 1'b0;
      dec     <= 1'b0;
      cnt     <= '0;
      rdata_q <= '0;
      rresp_q <= '0;
      rlast_q <= 1'b0;
      rid_q   <= '0;
      bresp_q <= '0;
      bid_q   <= '0;
    end else begin
      if (aw_hs) begin
        rr_rd <= 1'b1;
        addr  <= bus.awaddr;
        id    <= bus.awid;
        len   <= bus.awlen;
        size  <= bus.awsize;
        fixed <= (bus.awburst == 2'b00);
        slv   <= aw_slv;
        dec   <= 1'b0;
        cnt   <= '0;
      end
      if (ar_hs) begin
        rr_rd   <= 1'b0;
        addr    <= naddr;
        id      <= bus.arid;
        len     <= bus.arlen;
        size    <= bus.arsize;
        fixed   <= (bus.arburst == 2'b00);
        slv     <= ar_slv;
        cnt     <= 9'd1;
        rdata_q <= in_rng ? mem[idx] : '0;
        rresp_q <= beat_resp;
        rlast_q <= (bus.arlen == 8'd0);
        rid_q   <= bus.arid;
      end
      if (w_hs) begin
        addr <= naddr;
        cnt  <= cnt + 9'd1;
        if (!in_rng) dec <= 1'b1;
        if (bus.wlast) begin
          bid_q <= id;
          if (!in_rng || dec)                    bresp_q <= 2'b11;
          else if (slv || cnt != {1'b0, len})    bresp_q <= 2'b10;
          else                                   bresp_q <= 2'b00;
        end
      end
      if (r_hs) begin
        if (rlast_q) begin
          rlast_q <= 1'b0;
        end else begin
          rdata_q <= in_rng ? mem[idx] : '0;
          rresp_q <= beat_resp;
          rlast_q <= (cnt == {1'b0, len});
          addr    <= naddr;
          cnt     <= cnt + 9'd1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_hs && in_rng) begin
      for (int b = 0; b < BYTES; b++) begin
        if (bus.wstrb[b]) mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.rresp = rresp_q;
  assign bus.rlast = rlast_q;
  assign bus.rid   = rid_q;
  assign bus.bresp = bresp_q;
  assign bus.bid   = bid_q;
endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave; expected responses are queued
// by the stimulus and checked by a negedge monitor.
module tb_axi4_sram_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_sram_slave_if bus ();

  axi4_sram_slave dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0] resp;
    logic [3:0] id;
  } b_exp_t;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } r_exp_t;

  b_exp_t exp_b[$];
  r_exp_t exp_r[$];
  b_exp_t mb;
  r_exp_t mr;

  int errors = 0;
  int checks = 0;

  always @(negedge clk) begin
    if (bus.bvalid && bus.bready) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected: got resp=%b id=%0d, none required",
                 bus.bresp, bus.bid);
      end else begin
        mb = exp_b.pop_front();
        if (bus.bresp !== mb.resp || bus.bid !== mb.id) begin
          errors++;
          $display("FAIL bresp: got resp=%b id=%0d, required resp=%b id=%0d",
                   bus.bresp, bus.bid, mb.resp, mb.id);
        end
      end
    end
    if (bus.rvalid && bus.rready) begin
      checks++;
      if (exp_r.size() == 0) begin
        errors++;
        $display("FAIL r_unexpected: got d=%h resp=%b last=%b, none required",
                 bus.rdata, bus.rresp, bus.rlast);
      end else begin
        mr = exp_r.pop_front();
        if (bus.rdata !== mr.d || bus.rresp !== mr.resp ||
            bus.rlast !== mr.last || bus.rid !== mr.id) begin
          errors++;
          $display("FAIL rbeat: got d=%h resp=%b last=%b id=%0d, required d=%h resp=%b last=%b id=%0d",
                   bus.rdata, bus.rresp, bus.rlast, bus.rid,
                   mr.d, mr.resp, mr.last, mr.id);
        end
      end
    end
  end

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out, got no handshake, required one", name);
  endtask

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic push_r(input logic [31:0] d, input logic [1:0] resp,
                        input logic last, input logic [3:0] id);
    r_exp_t e;
    e.d = d; e.resp = resp; e.last = last; e.id = id;
    exp_r.push_back(e);
  endtask

  task automatic push_b(input logic [1:0] resp, input logic [3:0] id);
    b_exp_t e;
    e.resp = resp; e.id = id;
    exp_b.push_back(e);
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [3:0] id,
                         input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst);
    bit ok = 0;
    bus.awaddr = a; bus.awid = id; bus.awlen = len;
    bus.awsize = size; bus.awburst = burst; bus.awvalid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = bus.awready;
    end
    if (!ok) timeout("aw_handshake");
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [3:0] id,
                         input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst);
    bit ok = 0;
    bus.araddr = a; bus.arid = id; bus.arlen = len;
    bus.arsize = size; bus.arburst = burst; bus.arvalid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = bus.arready;
    end
    if (!ok) timeout("ar_handshake");
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] strb,
                        input logic last);
    bit ok = 0;
    bus.wdata = d; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = bus.wready;
    end
    if (!ok) timeout("w_handshake");
    @(posedge clk); #1;
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic wait_b();
    bit ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = bus.bvalid && bus.bready;
    end
    if (!ok) timeout("b_handshake");
    @(posedge clk); #1;
  endtask

  task automatic wait_rlast();
    bit ok = 0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      ok = bus.rvalid && bus.rready && bus.rlast;
    end
    if (!ok) timeout("r_last");
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] id,
                          input logic [7:0] len, input logic [1:0] burst,
                          input logic [31:0] d0, input logic [31:0] st,
                          input logic [3:0] strb, input int nb,
                          input logic [1:0] er);
    push_b(er, id);
    aw_send(a, id, len, 3'd2, burst);
    for (int i = 0; i < nb; i++)
      w_beat(d0 + st * 32'(i), strb, i == nb - 1);
    wait_b();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] id,
                         input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst);
    ar_send(a, id, len, size, burst);
    wait_rlast();
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.awvalid = 0; bus.awaddr = 0; bus.awid = 0; bus.awlen = 0;
    bus.awsize = 0; bus.awburst = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0;
    bus.bready = 1;
    bus.arvalid = 0; bus.araddr = 0; bus.arid = 0; bus.arlen = 0;
    bus.arsize = 0; bus.arburst = 0;
    bus.rready = 1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctl",
          {26'd0, bus.awready, bus.arready, bus.wready,
           bus.bvalid, bus.rvalid, bus.rlast}, 32'd0);
    check("reset_rdata", bus.rdata, 32'd0);
    check("reset_ids", {20'd0, bus.bresp, bus.rresp, bus.bid, bus.rid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single write/read
    do_write(32'h8000_0010, 4'd1, 8'd0, 2'b01, 32'hDEADBEEF, 0, 4'hF, 1, 2'b00);
    push_r(32'hDEADBEEF, 2'b00, 1'b1, 4'd2);
    do_read(32'h8000_0010, 4'd2, 8'd0, 3'd2, 2'b01);

    // INCR burst of four
    do_write(32'h8000_0020, 4'd3, 8'd3, 2'b01, 32'd1, 32'd1, 4'hF, 4, 2'b00);
    push_r(32'd1, 2'b00, 1'b0, 4'd4);
    push_r(32'd2, 2'b00, 1'b0, 4'd4);
    push_r(32'd3, 2'b00, 1'b0, 4'd4);
    push_r(32'd4, 2'b00, 1'b1, 4'd4);
    do_read(32'h8000_0020, 4'd4, 8'd3, 3'd2, 2'b01);

    // partial strobe over a cleared word
    do_write(32'h8000_0000, 4'd5, 8'd0, 2'b01, 32'h0, 0, 4'hF, 1, 2'b00);
    do_write(32'h8000_0000, 4'd5, 8'd0, 2'b01, 32'hAABBCCDD, 0, 4'b0101, 1, 2'b00);
    push_r(32'h00BB00DD, 2'b00, 1'b1, 4'd6);
    do_read(32'h8000_0000, 4'd6, 8'd0, 3'd2, 2'b01);

    // out of range read, early wlast, oversize, out of range write
    push_r(32'h0, 2'b11, 1'b1, 4'd7);
    do_read(32'h0000_0000, 4'd7, 8'd0, 3'd2, 2'b01);
    do_write(32'h8000_0040, 4'd8, 8'd3, 2'b01, 32'h40, 1, 4'hF, 2, 2'b10);
    push_r(32'hDEADBEEF, 2'b10, 1'b1, 4'd9);
    do_read(32'h8000_0010, 4'd9, 8'd0, 3'd3, 2'b01);
    do_write(32'h0000_0100, 4'd10, 8'd0, 2'b01, 32'h1, 0, 4'hF, 1, 2'b11);

    // FIXED and WRAP bursts
    do_write(32'h8000_0060, 4'd11, 8'd1, 2'b00, 32'h11, 32'h11, 4'hF, 2, 2'b00);
    push_r(32'h22, 2'b00, 1'b1, 4'd12);
    do_read(32'h8000_0060, 4'd12, 8'd0, 3'd2, 2'b01);
    do_write(32'h8000_0070, 4'd13, 8'd1, 2'b10, 32'd7, 32'd1, 4'hF, 2, 2'b10);
    push_r(32'd7, 2'b00, 1'b0, 4'd14);
    push_r(32'd8, 2'b00, 1'b1, 4'd14);
    do_read(32'h8000_0070, 4'd14, 8'd1, 3'd2, 2'b01);

    // burst crossing the top of memory
    do_write(32'h8000_3FFC, 4'd1, 8'd0, 2'b01, 32'hCAFE0001, 0, 4'hF, 1, 2'b00);
    push_r(32'hCAFE0001, 2'b00, 1'b0, 4'd2);
    push_r(32'h0, 2'b11, 1'b1, 4'd2);
    do_read(32'h8000_3FFC, 4'd2, 8'd1, 3'd2, 2'b01);

    // simultaneous AW and AR, round-robin order
    pulse_reset();
    bus.awaddr = 32'h8000_0200; bus.awid = 4'd3; bus.awlen = 0;
    bus.awsize = 3'd2; bus.awburst = 2'b01; bus.awvalid = 1'b1;
    bus.araddr = 32'h8000_0010; bus.arid = 4'd7; bus.arlen = 0;
    bus.arsize = 3'd2; bus.arburst = 2'b01; bus.arvalid = 1'b1;
    @(negedge clk);
    check("grant_first", {30'd0, bus.awready, bus.arready}, 32'b10);
    push_b(2'b00, 4'd3);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    w_beat(32'h55, 4'hF, 1'b1);
    wait_b();
    bus.awaddr = 32'h8000_0204; bus.awid = 4'd4; bus.awvalid = 1'b1;
    @(negedge clk);
    check("grant_second", {30'd0, bus.awready, bus.arready}, 32'b01);
    push_r(32'hDEADBEEF, 2'b00, 1'b1, 4'd7);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    wait_rlast();
    push_b(2'b00, 4'd4);
    aw_send(32'h8000_0204, 4'd4, 8'd0, 3'd2, 2'b01);
    w_beat(32'h66, 4'hF, 1'b1);
    wait_b();
    push_r(32'h55, 2'b00, 1'b0, 4'd5);
    push_r(32'h66, 2'b00, 1'b1, 4'd5);
    do_read(32'h8000_0200, 4'd5, 8'd1, 3'd2, 2'b01);

    // backpressure, then reset mid-burst
    do_write(32'h8000_0100, 4'd6, 8'd7, 2'b01, 32'h100, 32'd1, 4'hF, 8, 2'b00);
    for (int i = 0; i < 8; i++)
      push_r(32'h100 + 32'(i), 2'b00, i == 7, 4'd5);
    ar_send(32'h8000_0100, 4'd5, 8'd7, 3'd2, 2'b01);
    k = 0;
    for (int n = 0; n < 100 && k < 2; n++) begin
      @(negedge clk);
      if (bus.rvalid && bus.rready) k++;
    end
    @(posedge clk); #1;
    bus.rready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold",
            {bus.rdata[27:0], bus.rvalid, bus.rlast, bus.rid[1:0]},
            {28'h0000102, 1'b1, 1'b0, 2'b01});
    end
    @(posedge clk); #1;
    bus.rready = 1'b1;
    for (int n = 0; n < 100 && k < 4; n++) begin
      @(negedge clk);
      if (bus.rvalid && bus.rready) k++;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("reset_abort", {31'd0, bus.rvalid}, 32'd0);
    exp_r.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    push_r(32'h100, 2'b00, 1'b1, 4'd9);
    do_read(32'h8000_0100, 4'd9, 8'd0, 3'd2, 2'b01);

    repeat (5) @(posedge clk);
    check("queues_drained", 32'(exp_b.size() + exp_r.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
